// File: rtl/pmem_pkg.sv
// Shared definitions for the timed physical-memory controller: size codes,
// FSM state type and byte-enable helper.
package pmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } pmem_state_t;

    // Byte enables for a 2^size access starting at byte lane 'lane' (8-lane view).
    function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] lane);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << lane;
    endfunction

endpackage

// File: rtl/pmem_align.sv
// Combinational lane alignment: store data/byte-enable placement, load
// extraction with sign/zero extension, and natural-alignment check.
module pmem_align
    import pmem_pkg::*;
#(
    parameter  int XLEN   = 64,
    localparam int NB     = XLEN / 8,
    localparam int LANE_W = $clog2(NB)
) (
    input  logic [1:0]        size,
    input  logic [LANE_W-1:0] lane,
    input  logic              sgn,
    input  logic [XLEN-1:0]   rword,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   wdata_sh,
    output logic [NB-1:0]     ben,
    output logic [XLEN-1:0]   rdata_ext,
    output logic              misaligned
);

    logic [2:0]      lane3;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sb;

    always_comb begin
        lane3    = 3'(lane);
        shifted  = rword >> {lane, 3'b000};
        wdata_sh = wdata << {lane, 3'b000};
        ben      = NB'(byte_en(size, lane3));
        case (size)
            SZ_B: begin
                mask       = XLEN'(8'hFF);
                sb         = shifted[7];
                misaligned = 1'b0;
            end
            SZ_H: begin
                mask       = XLEN'(16'hFFFF);
                sb         = shifted[15];
                misaligned = lane3[0];
            end
            SZ_W: begin
                mask       = XLEN'(32'hFFFF_FFFF);
                sb         = shifted[31];
                misaligned = |lane3[1:0];
            end
            default: begin
                mask       = '1;
                sb         = 1'b0;
                misaligned = |lane3;
            end
        endcase
        rdata_ext = (shifted & mask) | ((sgn && sb) ? ~mask : '0);
    end

endmodule

// File: rtl/pmem_ctrl.sv
// Timed word-array memory with one outstanding access, valid/ready request
// and response channels, and programmable access latency.
module pmem_ctrl #(
    parameter int          XLEN      = 64,
    parameter int          ADDR_W    = 64,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic              req_signed,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);
    import pmem_pkg::*;

    localparam int NB     = XLEN / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH * NB);

    logic [XLEN-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] off;
    logic [IDX_W-1:0]  idx;
    logic [LANE_W-1:0] lane;
    logic              oor, illegal, mis, err, accept;
    logic [XLEN-1:0]   rword, wdata_sh, rdata_ext;
    logic [NB-1:0]     ben;

    pmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic             err_q, err_d;

    assign off     = req_addr - BASE;
    assign oor     = (req_addr < BASE) || (off >= SPAN);
    assign idx     = off[IDX_W+LANE_W-1:LANE_W];
    assign lane    = off[LANE_W-1:0];
    assign illegal = (XLEN == 32) && (req_size == SZ_D);
    assign err     = oor || illegal || mis;
    assign rword   = mem_q[idx];
    assign accept  = (state_q == ST_IDLE) && req_valid;

    pmem_align #(.XLEN(XLEN)) u_align (
        .size       (req_size),
        .lane       (lane),
        .sgn        (req_signed),
        .rword      (rword),
        .wdata      (req_wdata),
        .wdata_sh   (wdata_sh),
        .ben        (ben),
        .rdata_ext  (rdata_ext),
        .misaligned (mis)
    );

    // Array is not reset; stores commit on the accept edge.
    always_ff @(posedge clock) begin
        if (!reset && accept && req_wen && !err) begin
            for (int b = 0; b < NB; b++) begin
                if (ben[b]) mem_q[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rdata_d     = (req_wen || err) ? '0 : rdata_ext;
                    err_d       = err;
                    req_ready_d = 1'b0;
                    if (LATENCY == 1) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    rdata_d      = '0;
                    err_d        = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_pmem_ctrl.sv
// Bench for pmem_ctrl: two instances (LATENCY=2 and LATENCY=1) driven by
// directed and random accesses, checked against a byte-level memory model.
module tb_pmem_ctrl;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam logic [63:0] SPAN  = 64'(DEPTH * 8);

    logic        clock = 1'b0;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_wen    [2];
    logic        req_signed [2];
    logic [1:0]  req_size   [2];
    logic [63:0] req_addr   [2];
    logic [63:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [63:0] resp_rdata [2];
    logic        resp_err   [2];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mdl [longint unsigned];

    always #5 clock = ~clock;

    pmem_ctrl #(.LATENCY(2)) u_dut0 (
        .clock(clock), .reset(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
        .req_signed(req_signed[0]), .req_size(req_size[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    pmem_ctrl #(.LATENCY(1)) u_dut1 (
        .clock(clock), .reset(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
        .req_signed(req_signed[1]), .req_size(req_size[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned key(input int u, input longint unsigned off);
        return (longint'(u) << 40) | off;
    endfunction

    // Reference: byte-addressed memory, error rules from address/size arithmetic.
    function automatic void model(input int u, input bit wen, input bit sgn, input logic [1:0] size,
                                  input logic [63:0] addr, input logic [63:0] wdata,
                                  output logic [63:0] erd, output bit eerr);
        longint unsigned off;
        int n;
        logic [63:0] v;
        n    = 1 << size;
        off  = addr - BASE;
        eerr = (addr < BASE) || (off >= SPAN) || ((off % n) != 0);
        erd  = '0;
        if (eerr) return;
        if (wen) begin
            for (int i = 0; i < n; i++) mdl[key(u, off + i)] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v |= 64'(mdl[key(u, off + i)]) << (8 * i);
            if (sgn && n < 8 && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
            erd = v;
        end
    endfunction

    task automatic xact(input int u, input bit wen, input bit sgn, input logic [1:0] size,
                        input logic [63:0] addr, input logic [63:0] wdata, input int hold,
                        output logic [63:0] rd, output logic er);
        int          lat;
        logic [63:0] erd;
        bit          eerr;
        model(u, wen, sgn, size, addr, wdata, erd, eerr);
        @(negedge clock);
        chk("req_ready_idle", 64'(req_ready[u]), 64'd1);
        req_valid[u]  = 1'b1;
        req_wen[u]    = wen;
        req_signed[u] = sgn;
        req_size[u]   = size;
        req_addr[u]   = addr;
        req_wdata[u]  = wdata;
        @(posedge clock);
        #1;
        // Keep valid high with garbage while busy; it must be ignored.
        req_wen[u]    = 1'($urandom);
        req_signed[u] = 1'($urandom);
        req_size[u]   = 2'($urandom);
        req_addr[u]   = BASE + 64'($urandom_range(0, 63));
        req_wdata[u]  = {$urandom, $urandom};
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!resp_valid[u] && lat < 16);
        chk("latency", 64'(lat), (u == 0) ? 64'd2 : 64'd1);
        chk("busy_not_ready", 64'(req_ready[u]), 64'd0);
        chk("rdata", resp_rdata[u], erd);
        chk("err", 64'(resp_err[u]), 64'(eerr));
        rd = resp_rdata[u];
        er = resp_err[u];
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("bp_valid", 64'(resp_valid[u]), 64'd1);
            chk("bp_rdata", resp_rdata[u], erd);
            chk("bp_ready", 64'(req_ready[u]), 64'd0);
        end
        resp_ready[u] = 1'b1;
        req_valid[u]  = 1'b0;
        @(negedge clock);
        resp_ready[u] = 1'b0;
        chk("ready_back", 64'(req_ready[u]), 64'd1);
        chk("valid_drop", 64'(resp_valid[u]), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd, erd, addr;
        logic        er;
        bit          eerr;
        int          u, r, hold;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 0; req_wen[i] = 0; req_signed[i] = 0; req_size[i] = 0;
            req_addr[i] = 0; req_wdata[i] = 0; resp_ready[i] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", 64'(req_ready[i]), 64'd1);
            chk("rst_resp_valid", 64'(resp_valid[i]), 64'd0);
            chk("rst_rdata", resp_rdata[i], 64'd0);
            chk("rst_err", 64'(resp_err[i]), 64'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 8; a++)
                xact(i, 1, 0, 2'd3, BASE + 64'(8 * a), {$urandom, $urandom}, 0, rd, er);

        xact(0, 1, 0, 2'd3, BASE, 64'h1122334455667788, 0, rd, er);
        xact(0, 0, 0, 2'd3, BASE, 0, 0, rd, er);
        chk("dw_load", rd, 64'h1122334455667788);
        xact(0, 0, 1, 2'd0, BASE + 7, 0, 0, rd, er);
        chk("b7_signed", rd, 64'h11);
        xact(0, 1, 0, 2'd0, BASE + 1, 64'h80, 0, rd, er);
        xact(0, 0, 1, 2'd0, BASE + 1, 0, 0, rd, er);
        chk("b1_signed", rd, 64'hFFFF_FFFF_FFFF_FF80);
        xact(0, 0, 0, 2'd0, BASE + 1, 0, 0, rd, er);
        chk("b1_unsigned", rd, 64'h80);
        xact(0, 0, 0, 2'd3, BASE, 0, 0, rd, er);
        chk("dw_after_b", rd, 64'h1122334455668088);
        xact(0, 0, 0, 2'd1, BASE + 3, 0, 0, rd, er);
        chk("mis_half_err", 64'(er), 64'd1);
        xact(0, 0, 0, 2'd3, BASE, 0, 0, rd, er);
        chk("dw_after_mis", rd, 64'h1122334455668088);
        xact(0, 0, 0, 2'd3, 64'h7FFF_FFF8, 0, 0, rd, er);
        chk("oor_low", 64'(er), 64'd1);
        xact(0, 0, 0, 2'd3, BASE + SPAN, 0, 0, rd, er);
        chk("oor_high", 64'(er), 64'd1);
        xact(0, 0, 0, 2'd3, BASE, 0, 5, rd, er);

        // Reset during WAIT: store stays committed, response is dropped.
        @(negedge clock);
        req_valid[0] = 1; req_wen[0] = 1; req_size[0] = 2'd0;
        req_addr[0] = BASE + 2; req_wdata[0] = 64'h5A;
        @(posedge clock);
        #1 req_valid[0] = 0;
        model(0, 1, 0, 2'd0, BASE + 2, 64'h5A, erd, eerr);
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        chk("rstw_valid", 64'(resp_valid[0]), 64'd0);
        chk("rstw_ready", 64'(req_ready[0]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("rstw_no_resp", 64'(resp_valid[0]), 64'd0);
        end
        xact(0, 0, 0, 2'd3, BASE, 0, 0, rd, er);
        chk("dw_after_rst", rd, 64'h1122_3344_555A_8088);

        // LATENCY=1: response the cycle after accept, then reset in RESP.
        @(negedge clock);
        req_valid[1] = 1; req_wen[1] = 0; req_size[1] = 2'd3; req_addr[1] = BASE;
        @(posedge clock);
        #1 req_valid[1] = 0;
        @(negedge clock);
        chk("l1_valid", 64'(resp_valid[1]), 64'd1);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        chk("rstr_valid", 64'(resp_valid[1]), 64'd0);
        chk("rstr_ready", 64'(req_ready[1]), 64'd1);
        repeat (3) @(negedge clock);
        chk("rstr_no_resp", 64'(resp_valid[1]), 64'd0);

        for (int k = 0; k < 300; k++) begin
            u = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r == 0)      addr = BASE - 64'($urandom_range(1, 64));
            else if (r == 1) addr = BASE + SPAN + 64'($urandom_range(0, 64));
            else             addr = BASE + 64'($urandom_range(0, 63));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            xact(u, 1'($urandom), 1'($urandom), 2'($urandom), addr, {$urandom, $urandom}, hold, rd, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pmem_ctrl.md
Name: pmem_ctrl

Overview:
Parametrised, clocked successor to the combinational physical-memory model. Holds an internal word array and serves one outstanding load/store through a valid/ready request channel and a valid/ready response channel, with programmable access latency. Handles size and sign extension, misalignment and out-of-range checks internally, so the core LSU sees a realistic timed memory.

Parameters:
XLEN, 64, data width in bits; 32 or 64 only.
ADDR_W, 64, request address width.
BASE_ADDR, 64'h8000_0000, physical address mapped to word 0.
DEPTH, 4096, number of XLEN-bit words; power of two.
LATENCY, 2, cycles from request accept to resp_valid; minimum 1.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request
req_wen  in  1  1 = store, 0 = load
req_signed  in  1  load sign-extends when 1
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when XLEN=64)
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response
resp_rdata  out  XLEN  load result, extended; 0 for stores and errors
resp_err  out  1  misaligned, out-of-range or illegal size

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. The FSM returns to IDLE and the latency counter clears. Array contents are not reset.
- The FSM has three states: IDLE, WAIT and RESP.
- In IDLE, req_ready=1. When req_valid is 1, the request is accepted on the rising edge.
  - If LATENCY=1, the FSM goes straight to RESP.
  - Otherwise it goes to WAIT with the counter set to LATENCY-1.
- In WAIT, req_ready=0 and the counter decrements each cycle. When the counter reaches 1, the FSM moves to RESP on the next edge. resp_valid therefore rises exactly LATENCY cycles after the accept edge.
- In RESP, resp_valid=1 and req_ready=0. Outputs stay stable until resp_ready=1, which returns the FSM to IDLE. Back-to-back throughput is therefore at most one access per LATENCY+1 cycles.
- Address decode:
  - off = req_addr - BASE_ADDR.
  - Word index = off[log2(DEPTH)+log2(XLEN/8)-1 : log2(XLEN/8)].
  - Byte lane = off[log2(XLEN/8)-1:0].
  - The access is out of range when req_addr < BASE_ADDR or off >= DEPTH*XLEN/8.
- Error checks: an access is misaligned when the byte lane is not a multiple of 2^req_size. A size of 3 with XLEN=32 is an illegal size.
- Error response: misaligned, out-of-range or illegal-size accesses perform no array access, and the response carries resp_err=1 and resp_rdata=0.
- Stores:
  - Committed on the accept edge.
  - Only the 2^req_size bytes starting at the byte lane are written, from the low bytes of req_wdata; other bytes are unchanged.
  - Response: resp_rdata=0, resp_err=0.
- Loads:
  - The array word is read on the accept edge and the result is registered.
  - Selected bytes are shifted to bit 0, then sign-extended (req_signed=1) or zero-extended to XLEN.
  - resp_rdata is held until the handshake completes.
- Ordering: only one access is outstanding, so a load always observes all previously responded stores.
- Input sampling: req_* inputs are sampled only on the accept edge. Changes while req_ready=0 are ignored.
- A reset asserted in WAIT or RESP drops the in-flight response. A store already committed stays committed.

Decomposition:
- Shared package pmem_pkg holds:
  - size encoding constants SZ_B, SZ_H, SZ_W, SZ_D;
  - FSM state typedef pmem_state_t;
  - helper function for byte-enable generation from size and lane.
- One natural sub-module, pmem_align, is purely combinational. It takes size, lane, signed flag, raw word and write data, and produces the shifted write data, byte enables, extended load data and misaligned flag.
- The FSM, counter and array live in pmem_ctrl.

Test Plan:
- Dword store/load: with LATENCY=2, store dword 0x1122334455667788 at 0x80000000, then load dword unsigned. resp_valid arrives 2 cycles after each accept, and the load returns 0x1122334455667788 with resp_err=0.
- Byte load, sign/zero extension: load byte at 0x80000007 with signed=1 -> 0x0000000000000011. Store byte 0x80 at 0x80000001, load signed -> 0xFFFFFFFFFFFFFF80, load unsigned -> 0x80. The other bytes of the word are unchanged.
- Misaligned half: half load at 0x80000003 -> resp_err=1, resp_rdata=0. A following load of 0x80000000 shows the memory unchanged.
- Out-of-range: load at 0x7FFFFFF8 -> resp_err=1. Load at BASE_ADDR+DEPTH*8 -> resp_err=1.
- Response backpressure: hold resp_ready=0 for 5 cycles in RESP. resp_valid and resp_rdata stay stable, and req_ready stays 0 throughout. req_ready=1 returns the cycle after resp_ready=1.
- Reset mid-operation: assert reset during WAIT. Next cycle: resp_valid=0, req_ready=1, and no response is ever produced for the dropped request. Repeat with LATENCY=1 and check resp_valid rises the cycle after accept.
